pal_loader: RTL and testbench

PAL_LOADER -- requirements
Module: pal_loader

---
 rtl/nes_video_pkg.sv | 21 ++
 rtl/pal_loader_if.sv | 28 ++
 rtl/pal_loader.sv | 147 ++++++++++++++
 tb/tb_pal_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_video_pkg.sv
// Shared NES video constants and the palette loader state type.
package nes_video_pkg;

    localparam int unsigned PAL_ENTRIES         = 64;
    localparam int unsigned PAL_FILE_BYTES      = 192;
    localparam int unsigned PAL_EMPH_FILE_BYTES = 1536;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone,
        StError
    } pal_state_e;

    // File offset of byte 'sel' (0=R, 1=G, 2=B) of palette entry 'entry'.
    function automatic logic [10:0] pal_offset(input logic [5:0] entry, input logic [1:0] sel);
        return (11'(entry) * 11'd3) + 11'(sel);
    endfunction

endpackage

// File: rtl/pal_loader_if.sv
// Download byte stream in, palette RAM write port and status out.
interface pal_loader_if;

    logic        dl_active;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_addr;
    logic [7:0]  in_data;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic        done;
    logic        err;
    logic [6:0]  entries_loaded;

    modport master (
        output dl_active, in_valid, in_addr, in_data,
        input  in_ready, load_color, load_color_index, load_color_data, done, err,
               entries_loaded
    );

    modport slave (
        input  dl_active, in_valid, in_addr, in_data,
        output in_ready, load_color, load_color_index, load_color_data, done, err,
               entries_loaded
    );

endinterface

// File: rtl/pal_loader.sv
// Palette file loader: 3-byte {R,G,B} entries streamed into the 64-entry palette RAM.
// Define PAL_LOADER_EMPH_SKIP_EN to silently skip the tail of 1536-byte emphasis files.
module pal_loader
    import nes_video_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    pal_loader_if.slave  video
);

    pal_state_e  r_state;
    pal_state_e  w_state_nxt;
    logic        r_dl;
    logic [1:0]  r_sel;
    logic [5:0]  r_entry;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;
    logic        r_done;
    logic        r_err;
    logic [6:0]  r_cnt;

    logic        w_rise;
    logic        w_ready;
    logic        w_accept;
    logic [10:0] w_exp_addr;
    logic        w_addr_ok;
    logic        w_take_byte;
    logic        w_last_entry;
    logic        w_emph_drop;
    logic        w_enter_err;

    assign w_rise       = video.dl_active & ~r_dl;
    assign w_exp_addr   = pal_offset(r_entry, r_sel);
    assign w_addr_ok    = (video.in_addr == w_exp_addr);
    assign w_last_entry = (r_entry == 6'(PAL_ENTRIES - 1));

    // The edge cycle belongs to the new download, so no byte may slip through it.
    assign w_ready  = ((r_state == StCollect) || (r_state == StDone) || (r_state == StError))
                      & ~w_rise;
    assign w_accept = video.in_valid & w_ready;

`ifdef PAL_LOADER_EMPH_SKIP_EN
    assign w_emph_drop = (video.in_addr < 11'(PAL_EMPH_FILE_BYTES));
`else
    assign w_emph_drop = 1'b0;
`endif

    assign w_take_byte = (r_state == StCollect) & video.dl_active & w_accept & w_addr_ok;
    assign w_enter_err = (w_state_nxt == StError) & (r_state != StError);

    always_comb begin
        w_state_nxt = r_state;
        if (w_rise) begin
            w_state_nxt = StCollect;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_nxt = StIdle;
                end
                StCollect: begin
                    if (!video.dl_active) begin
                        w_state_nxt = StError;
                    end else if (w_accept) begin
                        if (!w_addr_ok) begin
                            w_state_nxt = StError;
                        end else if (r_sel == 2'd2) begin
                            w_state_nxt = StWrite;
                        end
                    end
                end
                StWrite: begin
                    w_state_nxt = w_last_entry ? StDone : StCollect;
                end
                StDone: begin
                    if (!video.dl_active) begin
                        w_state_nxt = StIdle;
                    end else if (w_accept && !w_emph_drop) begin
                        w_state_nxt = StError;
                    end
                end
                StError: begin
                    if (!video.dl_active) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            // Treat dl_active as already high so a download in flight is not restarted.
            r_dl    <= 1'b1;
            r_sel   <= 2'd0;
            r_entry <= 6'd0;
            r_r     <= 8'd0;
            r_g     <= 8'd0;
            r_b     <= 8'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 7'd0;
        end else begin
            r_state <= w_state_nxt;
            r_dl    <= video.dl_active;
            if (w_rise) begin
                r_sel   <= 2'd0;
                r_entry <= 6'd0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_cnt   <= 7'd0;
            end else begin
                if (w_enter_err) begin
                    r_err <= 1'b1;
                end
                if (w_take_byte) begin
                    case (r_sel)
                        2'd0:    r_r <= video.in_data;
                        2'd1:    r_g <= video.in_data;
                        default: r_b <= video.in_data;
                    endcase
                    r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
                end
                if (r_state == StWrite) begin
                    r_cnt   <= r_cnt + 7'd1;
                    r_entry <= r_entry + 6'd1;
                    if (w_last_entry) begin
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign video.in_ready         = w_ready;
    assign video.load_color       = (r_state == StWrite);
    assign video.load_color_index = r_entry;
    assign video.load_color_data  = {r_r, r_g, r_b};
    assign video.done             = r_done;
    assign video.err              = r_err;
    assign video.entries_loaded   = r_cnt;

endmodule

// File: tb/tb_pal_loader.sv
// Directed bench for pal_loader: table of whole-download scenarios plus reset/edge sequences.
module tb_pal_loader;

    typedef struct {
        string name;
        int    nbytes;
        int    jump_from;
        int    exp_strobes;
        int    exp_loaded;
        int    exp_done;
        int    exp_err;
    } scn_t;

    logic clk;
    logic reset;
    pal_loader_if bus ();

    pal_loader u_dut (
        .clk   (clk),
        .reset (reset),
        .video (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Monitor state
    bit          mon_on;
    bit          lat_en;
    bit          pend;
    bit          lc_prev;
    int          nstrobe;
    int          strobe_bad;
    int          b2b;
    int          rdy_bad;
    int          lat_bad;
    logic [23:0] cap [64];

    function automatic logic [7:0] file_byte(input int k);
        case (k)
            15:      return 8'h12;
            16:      return 8'h34;
            17:      return 8'h56;
            default: return 8'((k * 37 + 11) & 255);
        endcase
    endfunction

    function automatic logic [23:0] exp_entry(input int n);
        return {file_byte(3 * n), file_byte(3 * n + 1), file_byte(3 * n + 2)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.load_color) begin
                if (lc_prev) b2b++;
                if (bus.in_ready) rdy_bad++;
                if (lat_en && !pend) lat_bad++;
                if (nstrobe < 64) begin
                    cap[nstrobe] = bus.load_color_data;
                    if (int'(bus.load_color_index) != nstrobe ||
                        bus.load_color_data != exp_entry(nstrobe)) begin
                        strobe_bad++;
                    end
                end
                nstrobe++;
            end else if (lat_en && pend) begin
                lat_bad++;
            end
            pend = lat_en && bus.in_valid && bus.in_ready && bus.dl_active && !reset &&
                   (int'(bus.in_addr) % 3 == 2) && (int'(bus.in_addr) < 192);
            lc_prev = bus.load_color;
        end
    end

    task automatic send_byte(input int a);
        int n;
        bus.in_valid = 1'b1;
        bus.in_addr  = 11'(a);
        bus.in_data  = file_byte(a);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 20) begin
                chk("accept_timeout", a, -1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon(input bit lat);
        nstrobe    = 0;
        strobe_bad = 0;
        b2b        = 0;
        rdy_bad    = 0;
        lat_bad    = 0;
        pend       = 1'b0;
        lc_prev    = 1'b0;
        lat_en     = lat;
        for (int i = 0; i < 64; i++) cap[i] = 24'd0;
    endtask

    // Raise dl_active with a byte on the bus; it must not be taken on the edge cycle.
    task automatic start_dl(input string name);
        bus.dl_active = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 11'd0;
        bus.in_data   = file_byte(0);
        @(negedge clk);
        chk({name, "/edge_ready"}, int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "/clr_done"}, int'(bus.done), 0);
        chk({name, "/clr_err"}, int'(bus.err), 0);
        chk({name, "/clr_cnt"}, int'(bus.entries_loaded), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_scn(input scn_t s);
        bus.dl_active = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_mon(s.jump_from < 0);
        start_dl(s.name);
        for (int k = 0; k < s.nbytes; k++) begin
            send_byte((s.jump_from >= 0 && k > s.jump_from) ? k + 1 : k);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.dl_active = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({s.name, "/strobes"}, nstrobe, s.exp_strobes);
        chk({s.name, "/loaded"}, int'(bus.entries_loaded), s.exp_loaded);
        chk({s.name, "/done"}, int'(bus.done), s.exp_done);
        chk({s.name, "/err"}, int'(bus.err), s.exp_err);
        chk({s.name, "/strobe_data"}, strobe_bad, 0);
        chk({s.name, "/back_to_back"}, b2b, 0);
        chk({s.name, "/ready_in_write"}, rdy_bad, 0);
        chk({s.name, "/latency"}, lat_bad, 0);
        chk({s.name, "/idle_ready"}, int'(bus.in_ready), 0);
        if (s.exp_strobes > 5) chk({s.name, "/entry5"}, int'(cap[5]), 'h123456);
        @(posedge clk);
        #1;
    endtask

    scn_t tbl [4];
    scn_t full;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon_on  = 1'b0;
        clear_mon(1'b0);

        tbl[0] = '{name: "full", nbytes: 192, jump_from: -1, exp_strobes: 64, exp_loaded: 64,
                   exp_done: 1, exp_err: 0};
        tbl[1] = '{name: "addr_jump", nbytes: 20, jump_from: 9, exp_strobes: 3, exp_loaded: 3,
                   exp_done: 0, exp_err: 1};
        tbl[2] = '{name: "short", nbytes: 100, jump_from: -1, exp_strobes: 33, exp_loaded: 33,
                   exp_done: 0, exp_err: 1};
`ifdef PAL_LOADER_EMPH_SKIP_EN
        tbl[3] = '{name: "emph", nbytes: 1536, jump_from: -1, exp_strobes: 64, exp_loaded: 64,
                   exp_done: 1, exp_err: 0};
`else
        tbl[3] = '{name: "emph", nbytes: 1536, jump_from: -1, exp_strobes: 64, exp_loaded: 64,
                   exp_done: 1, exp_err: 1};
`endif
        full = tbl[0];

        reset         = 1'b1;
        bus.dl_active = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = 11'd0;
        bus.in_data   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/load_color", int'(bus.load_color), 0);
        chk("rst/index", int'(bus.load_color_index), 0);
        chk("rst/data", int'(bus.load_color_data), 0);
        chk("rst/done", int'(bus.done), 0);
        chk("rst/err", int'(bus.err), 0);
        chk("rst/loaded", int'(bus.entries_loaded), 0);
        chk("rst/ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < 4; i++) run_scn(tbl[i]);

        // Reset in the middle of a download, with dl_active still high.
        repeat (3) @(posedge clk);
        #1;
        clear_mon(1'b1);
        start_dl("midrst");
        for (int k = 0; k < 50; k++) send_byte(k);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst/load_color", int'(bus.load_color), 0);
        chk("midrst/index", int'(bus.load_color_index), 0);
        chk("midrst/data", int'(bus.load_color_data), 0);
        chk("midrst/done", int'(bus.done), 0);
        chk("midrst/err", int'(bus.err), 0);
        chk("midrst/loaded", int'(bus.entries_loaded), 0);
        chk("midrst/ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midrst/no_restart_ready", int'(bus.in_ready), 0);
        chk("midrst/no_restart_cnt", int'(bus.entries_loaded), 0);
        chk("midrst/strobes_before", nstrobe, 16);
        @(posedge clk);
        #1;
        run_scn(full);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
